// File: rtl/operand_fetch.sv
// operand_fetch: decode-to-execute operand fetch stage with a per-register RAW/WAW scoreboard.
// Define OF_BYPASS_EN to compile in same-cycle writeback forwarding and its bypass registers.
module operand_fetch #(
   parameter int AWIDTH = 8
) (
   input  logic              clk,
   input  logic              clear_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [AWIDTH-1:0] in_rs,
   input  logic [AWIDTH-1:0] in_rt,
   input  logic [AWIDTH-1:0] in_rd,
   input  logic              in_use_rs,
   input  logic              in_use_rt,
   input  logic              in_wr_en,
   input  logic [15:0]       in_imm,
   input  logic [5:0]        in_op,
   output logic [AWIDTH-1:0] rf_addr_rs,
   output logic [AWIDTH-1:0] rf_addr_rt,
   output logic              rf_req_rs,
   output logic              rf_req_rt,
   input  logic [15:0]       rf_rs,
   input  logic [15:0]       rf_rt,
   input  logic              wb_valid,
   input  logic [AWIDTH-1:0] wb_addr,
   input  logic [15:0]       wb_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [15:0]       out_rs_val,
   output logic [15:0]       out_rt_val,
   output logic [AWIDTH-1:0] out_rd,
   output logic              out_wr_en,
   output logic [15:0]       out_imm,
   output logic [5:0]        out_op
);
   localparam int NREG = 1 << AWIDTH;
   localparam logic [NREG-1:0] ONE_HOT0 = {{(NREG-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_READ  = 2'd1,
      S_VALID = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [NREG-1:0]   pend_q, pend_d, set_mask_s, clr_mask_s;
   logic              running_q;
   logic              use_rs_q, use_rs_d, use_rt_q, use_rt_d;
   logic [AWIDTH-1:0] rf_addr_rs_q, rf_addr_rs_d, rf_addr_rt_q, rf_addr_rt_d;
   logic              out_valid_q, out_valid_d;
   logic [15:0]       out_rs_val_q, out_rs_val_d, out_rt_val_q, out_rt_val_d;
   logic [AWIDTH-1:0] out_rd_q, out_rd_d;
   logic              out_wr_en_q, out_wr_en_d;
   logic [15:0]       out_imm_q, out_imm_d;
   logic [5:0]        out_op_q, out_op_d;
   logic              fwd_rs_s, fwd_rt_s, hazard_s, accept_s;
   logic [15:0]       rs_src_s, rt_src_s;

`ifdef OF_BYPASS_EN
   logic              byp_rs_q, byp_rs_d, byp_rt_q, byp_rt_d;
   logic [15:0]       byp_data_q, byp_data_d;

   assign fwd_rs_s = wb_valid && (wb_addr == in_rs);
   assign fwd_rt_s = wb_valid && (wb_addr == in_rt);
   assign rs_src_s = byp_rs_q ? byp_data_q : rf_rs;
   assign rt_src_s = byp_rt_q ? byp_data_q : rf_rt;

   // The writeback committing at the accept edge is invisible to the RF read, so keep a copy.
   always_comb begin
      if (accept_s) begin
         byp_rs_d   = fwd_rs_s;
         byp_rt_d   = fwd_rt_s;
         byp_data_d = wb_data;
      end else begin
         byp_rs_d   = byp_rs_q;
         byp_rt_d   = byp_rt_q;
         byp_data_d = byp_data_q;
      end
   end

   // Bypass registers
   always_ff @(posedge clk or negedge clear_n) begin
      if (!clear_n) begin
         byp_rs_q   <= 1'b0;
         byp_rt_q   <= 1'b0;
         byp_data_q <= 16'h0000;
      end else begin
         byp_rs_q   <= byp_rs_d;
         byp_rt_q   <= byp_rt_d;
         byp_data_q <= byp_data_d;
      end
   end
`else
   logic unused_wb_data_s;

   assign fwd_rs_s         = 1'b0;
   assign fwd_rt_s         = 1'b0;
   assign rs_src_s         = rf_rs;
   assign rt_src_s         = rf_rt;
   assign unused_wb_data_s = ^wb_data;
`endif

   assign hazard_s = (in_use_rs && pend_q[in_rs] && !fwd_rs_s) ||
                     (in_use_rt && pend_q[in_rt] && !fwd_rt_s) ||
                     (in_wr_en  && pend_q[in_rd]);
   assign in_ready = running_q && !hazard_s &&
                     ((state_q == S_IDLE) || ((state_q == S_VALID) && out_ready));
   assign accept_s = in_valid && in_ready;

   assign rf_req_rs  = accept_s && in_use_rs;
   assign rf_req_rt  = accept_s && in_use_rt;
   assign rf_addr_rs = accept_s ? in_rs : rf_addr_rs_q;
   assign rf_addr_rt = accept_s ? in_rt : rf_addr_rt_q;

   // Set is applied after clear so a same-index set/clear leaves the entry pending.
   assign set_mask_s = (accept_s && in_wr_en) ? (ONE_HOT0 << in_rd) : {NREG{1'b0}};
   assign clr_mask_s = wb_valid ? (ONE_HOT0 << wb_addr) : {NREG{1'b0}};
   assign pend_d     = (pend_q & ~clr_mask_s) | set_mask_s;

   // Stage sequencing and payload capture
   always_comb begin
      state_d      = state_q;
      out_valid_d  = out_valid_q;
      out_rs_val_d = out_rs_val_q;
      out_rt_val_d = out_rt_val_q;
      case (state_q)
         S_IDLE: begin
            if (accept_s) state_d = S_READ;
            else          state_d = S_IDLE;
         end
         S_READ: begin
            state_d      = S_VALID;
            out_valid_d  = 1'b1;
            out_rs_val_d = use_rs_q ? rs_src_s : 16'h0000;
            out_rt_val_d = use_rt_q ? rt_src_s : 16'h0000;
         end
         S_VALID: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = accept_s ? S_READ : S_IDLE;
            end else begin
               out_valid_d = 1'b1;
               state_d     = S_VALID;
            end
         end
         default: begin
            state_d     = S_IDLE;
            out_valid_d = 1'b0;
         end
      endcase
      if (accept_s) begin
         use_rs_d     = in_use_rs;
         use_rt_d     = in_use_rt;
         rf_addr_rs_d = in_rs;
         rf_addr_rt_d = in_rt;
         out_rd_d     = in_rd;
         out_wr_en_d  = in_wr_en;
         out_imm_d    = in_imm;
         out_op_d     = in_op;
      end else begin
         use_rs_d     = use_rs_q;
         use_rt_d     = use_rt_q;
         rf_addr_rs_d = rf_addr_rs_q;
         rf_addr_rt_d = rf_addr_rt_q;
         out_rd_d     = out_rd_q;
         out_wr_en_d  = out_wr_en_q;
         out_imm_d    = out_imm_q;
         out_op_d     = out_op_q;
      end
   end

   // State, scoreboard and output registers
   always_ff @(posedge clk or negedge clear_n) begin
      if (!clear_n) begin
         state_q      <= S_IDLE;
         pend_q       <= {NREG{1'b0}};
         running_q    <= 1'b0;
         use_rs_q     <= 1'b0;
         use_rt_q     <= 1'b0;
         rf_addr_rs_q <= {AWIDTH{1'b0}};
         rf_addr_rt_q <= {AWIDTH{1'b0}};
         out_valid_q  <= 1'b0;
         out_rs_val_q <= 16'h0000;
         out_rt_val_q <= 16'h0000;
         out_rd_q     <= {AWIDTH{1'b0}};
         out_wr_en_q  <= 1'b0;
         out_imm_q    <= 16'h0000;
         out_op_q     <= 6'h00;
      end else begin
         state_q      <= state_d;
         pend_q       <= pend_d;
         running_q    <= 1'b1;
         use_rs_q     <= use_rs_d;
         use_rt_q     <= use_rt_d;
         rf_addr_rs_q <= rf_addr_rs_d;
         rf_addr_rt_q <= rf_addr_rt_d;
         out_valid_q  <= out_valid_d;
         out_rs_val_q <= out_rs_val_d;
         out_rt_val_q <= out_rt_val_d;
         out_rd_q     <= out_rd_d;
         out_wr_en_q  <= out_wr_en_d;
         out_imm_q    <= out_imm_d;
         out_op_q     <= out_op_d;
      end
   end

   assign out_valid  = out_valid_q;
   assign out_rs_val = out_rs_val_q;
   assign out_rt_val = out_rt_val_q;
   assign out_rd     = out_rd_q;
   assign out_wr_en  = out_wr_en_q;
   assign out_imm    = out_imm_q;
   assign out_op     = out_op_q;
endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch: vector table plus hand-written hazard, backpressure and reset sequences.
// Expected timing follows OF_BYPASS_EN when the bench is compiled with it.
module tb_operand_fetch;
   logic        clk = 1'b0;
   logic        clear_n = 1'b1;
   logic        in_valid = 1'b0, in_ready;
   logic [7:0]  in_rs = 8'h00, in_rt = 8'h00, in_rd = 8'h00;
   logic        in_use_rs = 1'b0, in_use_rt = 1'b0, in_wr_en = 1'b0;
   logic [15:0] in_imm = 16'h0000;
   logic [5:0]  in_op = 6'h00;
   logic [7:0]  rf_addr_rs, rf_addr_rt;
   logic        rf_req_rs, rf_req_rt;
   logic [15:0] rf_rs, rf_rt;
   logic        wb_valid = 1'b0;
   logic [7:0]  wb_addr = 8'h00;
   logic [15:0] wb_data = 16'h0000;
   logic        out_valid, out_ready = 1'b0;
   logic [15:0] out_rs_val, out_rt_val, out_imm;
   logic [7:0]  out_rd;
   logic        out_wr_en;
   logic [5:0]  out_op;

   logic [15:0] rf_mem [0:255];
   int n_vec = 0;
   int n_err = 0;

`ifdef OF_BYPASS_EN
   localparam logic BYP = 1'b1;
`else
   localparam logic BYP = 1'b0;
`endif

   typedef struct {
      logic [7:0]  rs, rt, rd;
      logic        use_rs, use_rt, wr_en;
      logic [15:0] imm;
      logic [5:0]  op;
      logic [15:0] exp_rs, exp_rt;
   } vec_t;

   operand_fetch #(.AWIDTH(8)) dut (
      .clk(clk), .clear_n(clear_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
      .in_use_rs(in_use_rs), .in_use_rt(in_use_rt), .in_wr_en(in_wr_en),
      .in_imm(in_imm), .in_op(in_op),
      .rf_addr_rs(rf_addr_rs), .rf_addr_rt(rf_addr_rt),
      .rf_req_rs(rf_req_rs), .rf_req_rt(rf_req_rt),
      .rf_rs(rf_rs), .rf_rt(rf_rt),
      .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_rs_val(out_rs_val), .out_rt_val(out_rt_val),
      .out_rd(out_rd), .out_wr_en(out_wr_en), .out_imm(out_imm), .out_op(out_op)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] init_val(input logic [7:0] a);
      case (a)
         8'h03:   return 16'h1234;
         8'h05:   return 16'hBEEF;
         default: return {a, a ^ 8'hA5};
      endcase
   endfunction

   // Register file with registered read; a write at the read edge is not seen by that read.
   always @(posedge clk or negedge clear_n) begin
      if (!clear_n) begin
         for (int i = 0; i < 256; i++) rf_mem[i] <= init_val(8'(i));
         rf_rs <= 16'h0000;
         rf_rt <= 16'h0000;
      end else begin
         if (rf_req_rs) rf_rs <= rf_mem[rf_addr_rs];
         if (rf_req_rt) rf_rt <= rf_mem[rf_addr_rt];
         if (wb_valid) rf_mem[wb_addr] <= wb_data;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input vec_t v);
      in_rs = v.rs; in_rt = v.rt; in_rd = v.rd;
      in_use_rs = v.use_rs; in_use_rt = v.use_rt; in_wr_en = v.wr_en;
      in_imm = v.imm; in_op = v.op;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      vec_t vecs [6];
      vec_t v;
      //          rs     rt     rd     urs   urt   wr    imm       op     exp_rs    exp_rt
      vecs[0] = '{8'h03, 8'h05, 8'h20, 1'b1, 1'b1, 1'b0, 16'hCAFE, 6'h2A, 16'h1234, 16'hBEEF};
      vecs[1] = '{8'h10, 8'h22, 8'h40, 1'b1, 1'b0, 1'b1, 16'h0001, 6'h01, 16'h10B5, 16'h0000};
      vecs[2] = '{8'h22, 8'hFF, 8'h41, 1'b0, 1'b1, 1'b1, 16'hFFFF, 6'h3F, 16'h0000, 16'hFF5A};
      vecs[3] = '{8'h00, 8'h01, 8'h00, 1'b0, 1'b0, 1'b0, 16'h8000, 6'h00, 16'h0000, 16'h0000};
      vecs[4] = '{8'hFF, 8'h00, 8'h00, 1'b1, 1'b1, 1'b1, 16'h5555, 6'h15, 16'hFF5A, 16'h00A5};
      vecs[5] = '{8'h05, 8'h05, 8'h42, 1'b1, 1'b1, 1'b0, 16'h0F0F, 6'h30, 16'hBEEF, 16'hBEEF};

      // Reset: an offered instruction must not be accepted or requested
      drive(vecs[0]);
      in_valid = 1'b1;
      #2 clear_n = 1'b0;
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         chk("rst_out_valid", out_valid, 1'b0);
         chk("rst_in_ready", in_ready, 1'b0);
         chk("rst_req_rs", rf_req_rs, 1'b0);
         chk("rst_req_rt", rf_req_rt, 1'b0);
         chk("rst_addr_rs", rf_addr_rs, 8'h00);
      end
      in_valid = 1'b0;
      clear_n = 1'b1;
      tick();
      @(negedge clk);
      chk("post_rst_ready", in_ready, 1'b1);
      chk("post_rst_valid", out_valid, 1'b0);
      tick();

      // Table: accept, READ cycle, VALID cycle with payload
      out_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         drive(vecs[i]);
         in_valid = 1'b1;
         @(negedge clk);
         chk("acc_ready", in_ready, 1'b1);
         chk("acc_req_rs", rf_req_rs, vecs[i].use_rs);
         chk("acc_req_rt", rf_req_rt, vecs[i].use_rt);
         chk("acc_addr_rs", rf_addr_rs, vecs[i].rs);
         chk("acc_addr_rt", rf_addr_rt, vecs[i].rt);
         tick();
         in_valid = 1'b0;
         @(negedge clk);
         chk("read_valid", out_valid, 1'b0);
         chk("read_ready", in_ready, 1'b0);
         chk("read_req_rs", rf_req_rs, 1'b0);
         chk("hold_addr_rs", rf_addr_rs, vecs[i].rs);
         tick();
         @(negedge clk);
         chk("vld_valid", out_valid, 1'b1);
         chk("vld_rs_val", out_rs_val, vecs[i].exp_rs);
         chk("vld_rt_val", out_rt_val, vecs[i].exp_rt);
         chk("vld_rd", out_rd, vecs[i].rd);
         chk("vld_wr_en", out_wr_en, vecs[i].wr_en);
         chk("vld_imm", out_imm, vecs[i].imm);
         chk("vld_op", out_op, vecs[i].op);
         tick();
      end

      // RAW: writer to r7 then a reader of r7
      v = '{8'h00, 8'h00, 8'h07, 1'b0, 1'b0, 1'b1, 16'h0007, 6'h07, 16'h0000, 16'h0000};
      drive(v);
      in_valid = 1'b1;
      @(negedge clk);
      chk("raw_writer_ready", in_ready, 1'b1);
      tick();
      v = '{8'h07, 8'h00, 8'h50, 1'b1, 1'b0, 1'b0, 16'h0A0A, 6'h08, 16'h0000, 16'h0000};
      drive(v);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("raw_stall", in_ready, 1'b0);
         tick();
      end
      wb_valid = 1'b1; wb_addr = 8'h07; wb_data = 16'h00AA;
      @(negedge clk);
      chk("raw_wb_cycle_ready", in_ready, BYP);
      tick();
      wb_valid = 1'b0;
      if (!BYP) begin
         @(negedge clk);
         chk("raw_late_ready", in_ready, 1'b1);
         tick();
      end
      in_valid = 1'b0;
      @(negedge clk);
      chk("raw_read_valid", out_valid, 1'b0);
      tick();
      @(negedge clk);
      chk("raw_valid", out_valid, 1'b1);
      chk("raw_rs_val", out_rs_val, 16'h00AA);
      chk("raw_rt_val", out_rt_val, 16'h0000);
      chk("raw_imm", out_imm, 16'h0A0A);
      tick();

      // WAW: two writers to r9; never relaxed by forwarding
      v = '{8'h00, 8'h00, 8'h09, 1'b0, 1'b0, 1'b1, 16'h0009, 6'h09, 16'h0000, 16'h0000};
      drive(v);
      in_valid = 1'b1;
      @(negedge clk);
      chk("waw_first_ready", in_ready, 1'b1);
      tick();
      v = '{8'h00, 8'h00, 8'h09, 1'b0, 1'b0, 1'b1, 16'h9999, 6'h19, 16'h0000, 16'h0000};
      drive(v);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("waw_stall", in_ready, 1'b0);
         tick();
      end
      wb_valid = 1'b1; wb_addr = 8'h09; wb_data = 16'h1111;
      @(negedge clk);
      chk("waw_wb_cycle_ready", in_ready, 1'b0);
      tick();
      wb_valid = 1'b0;
      @(negedge clk);
      chk("waw_ready", in_ready, 1'b1);
      tick();
      in_valid = 1'b0;
      @(negedge clk);
      tick();
      @(negedge clk);
      chk("waw_valid", out_valid, 1'b1);
      chk("waw_rd", out_rd, 8'h09);
      chk("waw_wr_en", out_wr_en, 1'b1);
      chk("waw_imm", out_imm, 16'h9999);
      tick();

      // Backpressure: payload frozen for 5 cycles, waiting instruction taken as out_ready rises
      out_ready = 1'b0;
      v = '{8'h03, 8'h05, 8'h60, 1'b1, 1'b1, 1'b0, 16'h1111, 6'h11, 16'h0000, 16'h0000};
      drive(v);
      in_valid = 1'b1;
      @(negedge clk);
      chk("bp_a_ready", in_ready, 1'b1);
      tick();
      v = '{8'h10, 8'h22, 8'h61, 1'b1, 1'b1, 1'b0, 16'h2222, 6'h22, 16'h0000, 16'h0000};
      drive(v);
      @(negedge clk);
      chk("bp_read_ready", in_ready, 1'b0);
      tick();
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("bp_valid", out_valid, 1'b1);
         chk("bp_rs_val", out_rs_val, 16'h1234);
         chk("bp_rt_val", out_rt_val, 16'hBEEF);
         chk("bp_imm", out_imm, 16'h1111);
         chk("bp_rd", out_rd, 8'h60);
         chk("bp_ready", in_ready, 1'b0);
         tick();
      end
      out_ready = 1'b1;
      @(negedge clk);
      chk("bp_release_ready", in_ready, 1'b1);
      chk("bp_release_req", rf_req_rs, 1'b1);
      tick();
      in_valid = 1'b0;
      @(negedge clk);
      chk("bp_b_read_valid", out_valid, 1'b0);
      tick();
      @(negedge clk);
      chk("bp_b_valid", out_valid, 1'b1);
      chk("bp_b_rs_val", out_rs_val, 16'h10B5);
      chk("bp_b_rt_val", out_rt_val, 16'h2287);
      chk("bp_b_imm", out_imm, 16'h2222);
      tick();

      // Reset in READ: discards the writer and its pending rd (r9 is also still pending here)
      v = '{8'h03, 8'h00, 8'h30, 1'b1, 1'b0, 1'b1, 16'h3333, 6'h33, 16'h0000, 16'h0000};
      drive(v);
      in_valid = 1'b1;
      @(negedge clk);
      chk("mrst_writer_ready", in_ready, 1'b1);
      tick();
      in_valid = 1'b0;
      #2 clear_n = 1'b0;
      #1;
      chk("mrst_valid", out_valid, 1'b0);
      chk("mrst_rd", out_rd, 8'h00);
      chk("mrst_imm", out_imm, 16'h0000);
      chk("mrst_ready", in_ready, 1'b0);
      #10 clear_n = 1'b1;
      tick();
      v = '{8'h30, 8'h00, 8'h09, 1'b1, 1'b0, 1'b1, 16'h4444, 6'h34, 16'h0000, 16'h0000};
      drive(v);
      in_valid = 1'b1;
      @(negedge clk);
      chk("mrst_reader_ready", in_ready, 1'b1);
      tick();
      in_valid = 1'b0;
      @(negedge clk);
      tick();
      @(negedge clk);
      chk("mrst_reader_valid", out_valid, 1'b1);
      chk("mrst_reader_rs", out_rs_val, 16'h3095);
      chk("mrst_reader_rd", out_rd, 8'h09);
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/operand_fetch.md
# operand_fetch

Operand-fetch stage between instruction decode and execute. Accepts a decoded instruction over a valid/ready handshake and issues read requests to the register file. It captures the registered read data one cycle later, forwarding a same-cycle writeback where needed, and presents both operands to execute over a second valid/ready handshake. A per-register scoreboard blocks RAW and WAW hazards against writes still in flight downstream.

## Interface
- `AWIDTH`, 8, register address width; the scoreboard has `1<<AWIDTH` entries
- `clk` in 1: the block's single clock.
- `clear_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: decode offers an instruction.
- `in_ready` out 1: this stage accepts the offered instruction.
- `in_rs`, `in_rt`, `in_rd` in AWIDTH each: source and destination register addresses.
- `in_use_rs`, `in_use_rt` in 1 each: the instruction reads rs / rt.
- `in_wr_en` in 1: the instruction will write rd.
- `in_imm` in 16: immediate, passed through unchanged.
- `in_op` in 6: opcode sideband, passed through unchanged.
- `rf_addr_rs`, `rf_addr_rt` out AWIDTH each: register-file read addresses.
- `rf_req_rs`, `rf_req_rt` out 1 each: register-file read strobes.
- `rf_rs`, `rf_rt` in 16 each: registered register-file read data.
- `wb_valid` in 1: writeback commits this cycle (the same strobe as the register-file write).
- `wb_addr` in AWIDTH, `wb_data` in 16: writeback address and data.
- `out_valid` out 1, `out_ready` in 1: handshake to execute.
- `out_rs_val`, `out_rt_val` out 16 each: resolved operands.
- `out_rd` out AWIDTH, `out_wr_en` out 1, `out_imm` out 16, `out_op` out 6: registered copies of the instruction fields.

## Operation
- States:
  - IDLE: empty.
  - READ: register-file read in progress.
  - VALID: `out_valid` is high.
- Hazard, combinational from current inputs and scoreboard `pend[]`:
  - `in_use_rs && pend[in_rs] && !fwd_rs`, or
  - `in_use_rt && pend[in_rt] && !fwd_rt`, or
  - `in_wr_en && pend[in_rd]`.
- `fwd_x` = `wb_valid && wb_addr==in_x` with `OF_BYPASS_EN`; otherwise 0.
- `in_ready` = `!hazard && (state==IDLE || (state==VALID && out_ready))`.
- Accept (`in_valid && in_ready`):
  - `rf_req_rs` = `in_use_rs`, `rf_req_rt` = `in_use_rt`, both combinational in the same cycle.
  - `rf_addr_*` = `in_*`.
  - Latch rd, wr_en, imm and op.
  - Latch `fwd_rs`/`fwd_rt` and `wb_data` into bypass registers.
  - Next state READ.
- Outside an accept, `rf_req_*` = 0 and `rf_addr_*` hold their last value.
- READ:
  - `out_rs_val` = bypass data if `fwd_rs` was latched, else `rf_rs`; 0 if rs unused. Same rule for rt.
  - Next state VALID.
- VALID:
  - Holds every output stable until `out_ready`.
  - On `out_ready`, go to READ if a new instruction is accepted in the same cycle, else IDLE.
- Scoreboard:
  - On accept with `in_wr_en`, set `pend[in_rd]`.
  - On `wb_valid`, clear `pend[wb_addr]`.
  - Set and clear of the same index in the same cycle leaves it set.
  - Writes to register 0 are tracked like any other register (no hardwired zero).
- Reset: state IDLE, all `pend` cleared, every output register 0 (`out_valid`=0, `rf_req_*`=0, `rf_addr_*`=0).
- Reset asserted mid-operation discards the in-flight instruction with no handshake.

## Timing
- Accept edge to `out_valid` high: 2 cycles.
- Sustained throughput: 1 instruction per 2 cycles when `out_ready` is held high.
- The register-file read samples at the accept edge. A write committing at that same edge is not visible in `rf_rs`/`rf_rt`, so it is covered only by the latched bypass.
- A dependent instruction waiting on a pending register becomes acceptable:
  - in the `wb_valid` cycle with the bypass;
  - in the cycle after it without the bypass.
- `in_ready` never depends on `in_valid`.
- `out_valid`, once high, does not drop and the output payload does not change until `out_ready`.

## Configuration
- `OF_BYPASS_EN` defined:
  - same-cycle writeback forwarding and the bypass registers are compiled in;
  - the fwd terms relax the RAW hazard.
- `OF_BYPASS_EN` undefined:
  - `fwd_*` is tied to 0 and the bypass registers are removed;
  - RAW stalls last one cycle longer.
- WAW stalling is identical in both builds.

## Test plan
- Reset value check: with `clear_n` low, assert `out_valid`=0, `in_ready`=0 until release, and `rf_req_*`=0.
- Basic fetch:
  - Preload r3=0x1234 and r5=0xBEEF.
  - Issue rs=3, rt=5, use both, `out_ready`=1.
  - `rf_req_*` pulse in the accept cycle; `out_valid` 2 cycles later with 0x1234/0xBEEF; imm and op pass through.
- RAW with writeback:
  - Issue wr_en rd=7, then an instruction reading r7.
  - The second instruction is stalled until writeback r7=0x00AA.
  - With the bypass it is accepted in the writeback cycle and `out_rs_val`=0x00AA. Without the bypass it is accepted one cycle later with the same value.
- WAW: two consecutive writers to rd=9; the second is stalled until `wb_valid` with `wb_addr`=9, with or without the bypass.
- Backpressure: hold `out_ready`=0 for 5 cycles in VALID; the payload stays stable and `in_ready`=0. When `out_ready` rises, a waiting instruction is accepted in that same cycle.
- Reset mid-READ: drop `clear_n` asynchronously; `out_valid` is 0 immediately, all `pend` are cleared, and the next instruction reading the old rd is accepted without a stall.
